uart_packet_decoder: RTL and testbench
======================================

Name: uart_packet_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream through the RxReady/RxEnable handshake.
- Hunts for framed packets, validates length and checksum, and buffers the payload internally.
- Releases a payload to the consumer as a valid/ready byte stream with a last marker, but only after the whole packet has validated.
- Reports framing failures as coded strobes plus saturating counters.

Parameters:
- CLOCK_FREQUENCY, 1_000_000, system clock in Hz; used only to size the timeout counter.
- SYNC_BYTE, 8'hA5, start-of-packet marker.
- MAX_LEN, 16, maximum payload length in bytes, range 1..255; sets the buffer depth.
- TIMEOUT_CYCLES, 10_000, maximum clocks allowed between consecutive bytes inside a packet.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- RxDataInput  in  8  byte from the UART receiver.
- RxReady  in  1  receiver holds a byte.
- RxError  in  1  receiver is in its error state.
- RxEnable  out  1  one-cycle acknowledge to the receiver.
- OutData  out  8  payload byte.
- OutValid  out  1  OutData is valid.
- OutLast  out  1  marks the final payload byte.
- OutReady  in  1  consumer accepts the byte.
- PacketLength  out  8  length of the packet currently being drained.
- ErrorStrobe  out  1  one-cycle pulse on any detected error.
- ErrorCode  out  2  0 = link, 1 = length, 2 = checksum, 3 = timeout; held until the next ErrorStrobe.
- LinkFault  out  1  sticky; set when RxError is seen, cleared only by reset.
- PacketCount  out  8  good packets, saturating at 255.
- ErrorCount  out  8  errors, saturating at 255.

Behaviour:
- Reset (Reset low, asynchronous):
  - State goes to HUNT.
  - All outputs go to 0.
  - Buffer contents are don't-care.
  - Reset mid-packet discards all partial data; no ErrorStrobe is generated.
- Packet format on the wire:
  - SYNC_BYTE, then LEN, then LEN payload bytes, then CHK.
  - CHK = XOR of LEN and every payload byte.
- Byte consume rule:
  - A byte is taken in any cycle where RxReady=1, RxEnable=0 and the state is not DRAIN.
  - RxEnable is registered: it is high for exactly the following cycle, then low.
  - The cycle in which RxEnable=1 never consumes, so a byte is never taken twice while the receiver is leaving its full state.
- State HUNT:
  - A consumed byte equal to SYNC_BYTE moves to LEN.
  - Any other consumed byte is discarded silently.
- State LEN:
  - LEN = 0 or LEN > MAX_LEN gives an error with code 1, then HUNT.
  - Otherwise: store the length, initialise the running XOR to LEN, set the index to 0, move to PAYLOAD.
- State PAYLOAD:
  - Each byte is written to buffer[index]; the XOR is updated and the index incremented.
  - After the byte at index LEN-1, move to CHECK.
- State CHECK:
  - If CHK equals the running XOR: move to DRAIN, set PacketLength = LEN, and increment PacketCount.
  - Otherwise: error with code 2, then HUNT.
- State DRAIN:
  - OutValid=1 and OutData = buffer[rdptr]; rdptr starts at 0.
  - OutLast=1 when rdptr = LEN-1.
  - A transfer occurs when OutValid and OutReady are both high.
  - The transfer of the last byte returns the state to HUNT, with OutValid low on the next cycle.
  - OutData, OutValid and OutLast stay stable while OutReady=0.
  - No RxEnable is issued in DRAIN. The consumer must drain within one byte time; overrun is the upstream receiver's own error.
- Timeout:
  - In LEN, PAYLOAD or CHECK, a counter clears on every consumed byte.
  - When it reaches TIMEOUT_CYCLES: error with code 3, then HUNT.
  - The counter is inactive in HUNT and DRAIN.
- RxError:
  - RxError=1 in any state other than DRAIN sets LinkFault, gives an error with code 0, and goes to HUNT.
  - While RxError stays high: no bytes are consumed and no further strobes are generated (edge-detected).
  - In DRAIN, draining completes first; the error is then taken if RxError is still high.
- Error action:
  - ErrorStrobe pulses high for one cycle and ErrorCode is updated.
  - ErrorCount increments, saturating at 255.
  - The buffer is discarded.
- Simultaneous events, priority order: RxError, then timeout, then consumed byte.

Test Plan:
- Good packet: bytes A5,03,11,22,33,CHK=03^11^22^33=03 with OutReady=1. Required: OutData 11,22,33 on consecutive cycles, OutLast on 33, PacketLength=3, PacketCount=1, no ErrorStrobe.
- Handshake: RxReady held high for 2 cycles per byte. Required: exactly one RxEnable pulse per byte and no duplicate buffer write; OutReady toggled 1,0,1 during DRAIN keeps OutData stable.
- Bad checksum: A5,02,AA,55,CHK=00 (expected 02^AA^55=FD). Required: ErrorStrobe once, ErrorCode=2, OutValid never high, ErrorCount=1, next A5 packet decodes correctly.
- Length errors: A5,00 gives ErrorCode=1; A5,11 with MAX_LEN=16 gives ErrorCode=1; junk 00,FF before A5 is ignored without error.
- Timeout: A5,04,01 then idle TIMEOUT_CYCLES clocks. Required: ErrorCode=3 strobe at exactly TIMEOUT_CYCLES after the last consume, state HUNT.
- Link fault and reset: RxError raised mid-payload gives a single strobe with ErrorCode=0 and LinkFault=1; Reset low mid-packet clears every output to 0 immediately (asynchronous).

Source files
------------

// File: rtl/uart_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_decoder
// Brief    : Hunts SYNC/LEN/payload/CHK frames in a UART byte stream, buffers
//            and validates them, then drains good payloads as valid/ready data.
// Revision : 1.0
// ============================================================================
module uart_packet_decoder #(
    parameter int         CLOCK_FREQUENCY = 1_000_000,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5,
    parameter int         MAX_LEN         = 16,
    parameter int         TIMEOUT_CYCLES  = 10_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] RxDataInput,
    input  logic       RxReady,
    input  logic       RxError,
    output logic       RxEnable,
    output logic [7:0] OutData,
    output logic       OutValid,
    output logic       OutLast,
    input  logic       OutReady,
    output logic [7:0] PacketLength,
    output logic       ErrorStrobe,
    output logic [1:0] ErrorCode,
    output logic       LinkFault,
    output logic [7:0] PacketCount,
    output logic [7:0] ErrorCount
);

    localparam int c_IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // Counter is wide enough for a full one-second gap, whichever is larger.
    localparam int c_TIMER_SPAN = (TIMEOUT_CYCLES > CLOCK_FREQUENCY) ? TIMEOUT_CYCLES : CLOCK_FREQUENCY;
    localparam int c_TIMER_W = $clog2(c_TIMER_SPAN + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_MAX_LEN  = 8'(MAX_LEN);
    localparam logic [1:0] c_ERR_LINK = 2'd0;
    localparam logic [1:0] c_ERR_LEN  = 2'd1;
    localparam logic [1:0] c_ERR_CHK  = 2'd2;
    localparam logic [1:0] c_ERR_TIME = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic                   r_rxEnable;
    logic                   r_linkArmed;
    logic [7:0]             r_len;
    logic [7:0]             r_xor;
    logic [7:0]             r_index;
    logic [7:0]             r_rdPtr;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_errStrobe;
    logic [1:0]             r_errCode;
    logic                   r_linkFault;
    logic [7:0]             r_pktLen;
    logic [7:0]             r_pktCount;
    logic [7:0]             r_errCount;
    logic [7:0]             r_buffer [MAX_LEN];

    logic                   w_byteAvail;
    logic                   w_linkErr;
    logic                   w_timerActive;
    logic                   w_timeout;
    logic                   w_take;
    logic                   w_err;
    logic [1:0]             w_errCode;
    logic                   w_goodPkt;
    logic                   w_xfer;
    logic                   w_lenBad;

    // The cycle with RxEnable high never consumes, so a lingering RxReady is not re-taken.
    assign w_byteAvail   = RxReady && !r_rxEnable && !RxError;
    assign w_linkErr     = RxError && r_linkArmed && (r_state != S_DRAIN);
    assign w_timerActive = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign w_timeout     = w_timerActive && (r_timer == c_TIMER_LAST);
    assign w_lenBad      = (RxDataInput == 8'd0) || (RxDataInput > c_MAX_LEN);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_take      = 1'b0;
        w_err       = 1'b0;
        w_errCode   = r_errCode;
        w_goodPkt   = 1'b0;
        w_xfer      = 1'b0;
        if (w_linkErr) begin
            w_err       = 1'b1;
            w_errCode   = c_ERR_LINK;
            w_stateNext = S_HUNT;
        end else if (w_timeout) begin
            w_err       = 1'b1;
            w_errCode   = c_ERR_TIME;
            w_stateNext = S_HUNT;
        end else begin
            case (r_state)
                S_HUNT: begin
                    if (w_byteAvail) begin
                        w_take = 1'b1;
                        if (RxDataInput == SYNC_BYTE) begin
                            w_stateNext = S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (w_byteAvail) begin
                        w_take = 1'b1;
                        if (w_lenBad) begin
                            w_err       = 1'b1;
                            w_errCode   = c_ERR_LEN;
                            w_stateNext = S_HUNT;
                        end else begin
                            w_stateNext = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_byteAvail) begin
                        w_take = 1'b1;
                        if (r_index == r_len - 8'd1) begin
                            w_stateNext = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_byteAvail) begin
                        w_take = 1'b1;
                        if (RxDataInput == r_xor) begin
                            w_goodPkt   = 1'b1;
                            w_stateNext = S_DRAIN;
                        end else begin
                            w_err       = 1'b1;
                            w_errCode   = c_ERR_CHK;
                            w_stateNext = S_HUNT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (OutReady) begin
                        w_xfer = 1'b1;
                        if (r_rdPtr == r_len - 8'd1) begin
                            w_stateNext = S_HUNT;
                        end
                    end
                end
                default: begin
                    w_stateNext = S_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rxEnable  <= 1'b0;
            r_linkArmed <= 1'b1;
            r_len       <= '0;
            r_xor       <= '0;
            r_index     <= '0;
            r_rdPtr     <= '0;
            r_timer     <= '0;
            r_errStrobe <= 1'b0;
            r_errCode   <= '0;
            r_linkFault <= 1'b0;
            r_pktLen    <= '0;
            r_pktCount  <= '0;
            r_errCount  <= '0;
        end else begin
            r_rxEnable  <= w_take;
            r_errStrobe <= w_err;
            // Re-arm only once RxError drops, so a held error strobes once.
            if (!RxError) begin
                r_linkArmed <= 1'b1;
            end else if (w_linkErr) begin
                r_linkArmed <= 1'b0;
            end
            if (w_linkErr) begin
                r_linkFault <= 1'b1;
            end
            if (w_err) begin
                r_errCode <= w_errCode;
                if (r_errCount != 8'hFF) begin
                    r_errCount <= r_errCount + 8'd1;
                end
            end
            if (w_take || w_err || !w_timerActive) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TIMER_W'(1);
            end
            if (w_take && (r_state == S_LEN)) begin
                r_len   <= RxDataInput;
                r_xor   <= RxDataInput;
                r_index <= '0;
            end
            if (w_take && (r_state == S_PAYLOAD)) begin
                r_xor   <= r_xor ^ RxDataInput;
                r_index <= r_index + 8'd1;
            end
            if (w_goodPkt) begin
                r_pktLen <= r_len;
                r_rdPtr  <= '0;
                if (r_pktCount != 8'hFF) begin
                    r_pktCount <= r_pktCount + 8'd1;
                end
            end else if (w_xfer) begin
                r_rdPtr <= r_rdPtr + 8'd1;
            end
        end
    end

    // Payload storage needs no reset; it is only read while draining a validated packet.
    always_ff @(posedge Clk) begin
        if (w_take && (r_state == S_PAYLOAD)) begin
            r_buffer[r_index[c_IDX_W-1:0]] <= RxDataInput;
        end
    end

    assign RxEnable     = r_rxEnable;
    assign OutValid     = (r_state == S_DRAIN);
    assign OutData      = OutValid ? r_buffer[r_rdPtr[c_IDX_W-1:0]] : 8'h00;
    assign OutLast      = OutValid && (r_rdPtr == r_len - 8'd1);
    assign PacketLength = r_pktLen;
    assign ErrorStrobe  = r_errStrobe;
    assign ErrorCode    = r_errCode;
    assign LinkFault    = r_linkFault;
    assign PacketCount  = r_pktCount;
    assign ErrorCount   = r_errCount;

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_decoder
// Brief    : Scoreboard bench for uart_packet_decoder with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_uart_packet_decoder;

    localparam int         c_MAX_LEN = 16;
    localparam int         c_TIMEOUT = 200;
    localparam logic [7:0] c_SYNC    = 8'hA5;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } exp_beat_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] RxDataInput = 8'h00;
    logic       RxReady = 1'b0;
    logic       RxError = 1'b0;
    logic       RxEnable;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutLast;
    logic       OutReady = 1'b1;
    logic [7:0] PacketLength;
    logic       ErrorStrobe;
    logic [1:0] ErrorCode;
    logic       LinkFault;
    logic [7:0] PacketCount;
    logic [7:0] ErrorCount;

    exp_beat_t expQ[$];
    int        errQ[$];
    int        xferCyc[$];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        lastEnCyc = 0;
    int        enPulses = 0;
    int        expPkt = 0;
    int        expErr = 0;
    bit        readyRandom = 1'b0;

    uart_packet_decoder #(
        .CLOCK_FREQUENCY(1_000_000),
        .SYNC_BYTE      (c_SYNC),
        .MAX_LEN        (c_MAX_LEN),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .RxDataInput (RxDataInput),
        .RxReady     (RxReady),
        .RxError     (RxError),
        .RxEnable    (RxEnable),
        .OutData     (OutData),
        .OutValid    (OutValid),
        .OutLast     (OutLast),
        .OutReady    (OutReady),
        .PacketLength(PacketLength),
        .ErrorStrobe (ErrorStrobe),
        .ErrorCode   (ErrorCode),
        .LinkFault   (LinkFault),
        .PacketCount (PacketCount),
        .ErrorCount  (ErrorCount)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT presents a beat or an error strobe.
    task automatic monitor();
        exp_beat_t  e;
        logic       prevValid = 1'b0;
        logic       prevReady = 1'b0;
        logic [7:0] prevData = 8'h00;
        logic       prevLast = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                prevValid = 1'b0;
                continue;
            end
            if (RxEnable) begin
                lastEnCyc = cyc;
                enPulses++;
            end
            if (prevValid && !prevReady) begin
                check("hold_stable", {OutValid, OutLast, OutData}, {1'b1, prevLast, prevData});
            end
            if (OutValid && OutReady) begin
                check("out_expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    check("out_beat", {OutData, OutLast, PacketLength}, {e.data, e.last, e.len});
                end
                xferCyc.push_back(cyc);
            end
            if (ErrorStrobe) begin
                check("err_expected", errQ.size() > 0, 1);
                if (errQ.size() > 0) begin
                    check("err_code", ErrorCode, errQ.pop_front());
                end
            end
            prevValid = OutValid;
            prevReady = OutReady;
            prevData  = OutData;
            prevLast  = OutLast;
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge Clk);
            #1;
            if (readyRandom) OutReady = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        int n = 0;
        RxDataInput = b;
        RxReady     = 1'b1;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (!RxEnable && n < 5000);
        check("send_ack", RxEnable, 1);
        if (hold) tick(1);
        RxReady = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] frame[$], input bit hold);
        foreach (frame[i]) send_byte(frame[i], hold);
    endtask

    // Frame-level model: expected output is derived straight from the wire format.
    task automatic send_packet(input logic [7:0] pl[$], input bit corrupt, input bit hold);
        logic [7:0] frame[$];
        logic [7:0] x;
        exp_beat_t  e;
        int         n;
        n = pl.size();
        x = 8'(n);
        frame.push_back(c_SYNC);
        frame.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            x = x ^ pl[i];
            frame.push_back(pl[i]);
            if (!corrupt) begin
                e.data = pl[i];
                e.last = (i == n - 1);
                e.len  = 8'(n);
                expQ.push_back(e);
            end
        end
        if (corrupt) begin
            frame.push_back(x ^ (8'h01 << $urandom_range(0, 7)));
            errQ.push_back(2);
            expErr++;
        end else begin
            frame.push_back(x);
            expPkt++;
        end
        send_frame(frame, hold);
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((expQ.size() != 0 || OutValid) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(2);
        check("drained", expQ.size(), 0);
        check("errors_seen", errQ.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!OutValid && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_entered", OutValid, 1);
    endtask

    task automatic check_counts();
        check("packet_count", PacketCount, expPkt);
        check("error_count", ErrorCount, expErr);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] fr[$];
        int         en0;
        int         n;
        int         kind;
        fork
            monitor();
            ready_driver();
        join_none

        // Power-on reset
        #3 Reset = 1'b0;
        #20;
        check("reset_state", {RxEnable, OutData, OutValid, OutLast, PacketLength, ErrorStrobe,
                              ErrorCode, LinkFault, PacketCount, ErrorCount}, 0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        tick(2);

        // Good packet with consecutive output beats
        xferCyc.delete();
        pl = {8'h11, 8'h22, 8'h33};
        send_packet(pl, 1'b0, 1'b0);
        wait_drained();
        check("beats_seen", xferCyc.size(), 3);
        if (xferCyc.size() == 3) check("beats_back_to_back", xferCyc[2] - xferCyc[0], 2);
        check("packet_length", PacketLength, 3);
        check_counts();

        // Two-cycle RxReady per byte plus stalled drain
        OutReady = 1'b0;
        en0 = enPulses;
        pl = {8'h44, 8'h55, 8'h66};
        send_packet(pl, 1'b0, 1'b1);
        wait_valid();
        check("one_ack_per_byte", enPulses - en0, 6);
        OutReady = 1'b1;
        tick(1);
        OutReady = 1'b0;
        tick(1);
        OutReady = 1'b1;
        wait_drained();

        // Bad checksum, then recovery
        fr = {c_SYNC, 8'h02, 8'hAA, 8'h55, 8'h00};
        errQ.push_back(2);
        expErr++;
        send_frame(fr, 1'b0);
        tick(3);
        check("chk_no_valid", OutValid, 0);
        pl = {8'h01, 8'hA5, 8'hFE};
        send_packet(pl, 1'b0, 1'b0);
        wait_drained();
        check_counts();

        // Length errors and junk
        fr = {8'h00, 8'hFF, c_SYNC, 8'h00};
        errQ.push_back(1);
        expErr++;
        send_frame(fr, 1'b0);
        fr = {c_SYNC, 8'(c_MAX_LEN + 1)};
        errQ.push_back(1);
        expErr++;
        send_frame(fr, 1'b0);
        wait_drained();
        check_counts();

        // Inter-byte timeout
        fr = {c_SYNC, 8'h04, 8'h01};
        errQ.push_back(3);
        expErr++;
        send_frame(fr, 1'b0);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!ErrorStrobe && n < c_TIMEOUT + 100);
        check("timeout_latency", cyc - lastEnCyc, c_TIMEOUT);
        pl = {8'h7E};
        send_packet(pl, 1'b0, 1'b0);
        wait_drained();
        check_counts();

        // Link error mid-payload
        check("link_fault_clear", LinkFault, 0);
        fr = {c_SYNC, 8'h04, 8'h01, 8'h02};
        send_frame(fr, 1'b0);
        errQ.push_back(0);
        expErr++;
        RxError = 1'b1;
        tick(6);
        check("link_fault_set", LinkFault, 1);
        RxError = 1'b0;
        tick(2);
        pl = {8'h9C, 8'h3D};
        send_packet(pl, 1'b0, 1'b0);
        wait_drained();
        check_counts();

        // Randomized frames under random backpressure
        readyRandom = 1'b1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            pl.delete();
            fr.delete();
            if (kind == 0) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin
                    fr.push_back(8'($urandom_range(0, 255)));
                    if (fr[i] == c_SYNC) fr[i] = 8'h5A;
                end
                send_frame(fr, 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                fr.push_back(c_SYNC);
                fr.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(c_MAX_LEN + 1, 255)));
                errQ.push_back(1);
                expErr++;
                send_frame(fr, 1'($urandom_range(0, 1)));
            end else begin
                n = $urandom_range(1, c_MAX_LEN);
                for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
                send_packet(pl, kind == 3, 1'($urandom_range(0, 1)));
            end
        end
        readyRandom = 1'b0;
        OutReady = 1'b1;
        wait_drained();
        check_counts();

        // Asynchronous reset in the middle of a drain
        OutReady = 1'b0;
        pl = {8'h12, 8'h34, 8'h56};
        send_packet(pl, 1'b0, 1'b0);
        wait_valid();
        Reset = 1'b0;
        #1;
        check("reset_mid_packet", {RxEnable, OutData, OutValid, OutLast, PacketLength, ErrorStrobe,
                                   ErrorCode, LinkFault, PacketCount, ErrorCount}, 0);
        expQ.delete();
        errQ.delete();
        expPkt = 0;
        expErr = 0;
        tick(1);
        Reset = 1'b1;
        OutReady = 1'b1;
        tick(1);
        pl = {8'hC3, 8'h3C};
        send_packet(pl, 1'b0, 1'b0);
        wait_drained();
        check_counts();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
